// File: rtl/pipelined_imm_gen_if.sv
// Handshake bundle for pipelined_imm_gen: instruction-in channel and decoded-immediate-out channel.
// A beat moves on a channel in any cycle where its valid and ready are both high at the rising edge.
// A source holds valid and payload until it sees ready, and a sink may not make ready depend on valid.
interface pipelined_imm_gen_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illegal
    );
endinterface

// File: rtl/pipelined_imm_gen.sv
// RISC-V immediate generator behind a two-entry pipeline (output register plus skid entry).
// Define IMMGEN_UTYPE_EN to decode LUI/AUIPC as U-type; otherwise they are reported illegal.
module pipelined_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    pipelined_imm_gen_if.slave imm_if
);
    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_J    = 3'd5;
`ifdef IMMGEN_UTYPE_EN
    localparam logic [2:0] TYPE_U    = 3'd4;
`endif

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            ill;
    } entry_t;

    logic        [31:0] inst;
    logic signed [31:0] imm32;
    entry_t             dec;
    entry_t             out_q, out_d;
    entry_t             skid_q, skid_d;
    logic               out_valid_q, out_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               accept;
    logic               deliver;

    assign inst = imm_if.in_inst;

    // Every format is first built as a 32-bit signed value, then widened with its sign to XLEN.
    always_comb begin
        imm32   = '0;
        dec.typ = TYPE_NONE;
        dec.ill = 1'b0;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec.typ = TYPE_I;
                imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                dec.typ = TYPE_S;
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                dec.typ = TYPE_B;
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b1101111: begin
                dec.typ = TYPE_J;
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b0110011, 7'b1110011: begin
                dec.typ = TYPE_NONE;
            end
`ifdef IMMGEN_UTYPE_EN
            7'b0110111, 7'b0010111: begin
                dec.typ = TYPE_U;
                imm32   = {inst[31:12], 12'b0};
            end
`endif
            default: begin
                dec.ill = 1'b1;
            end
        endcase
        dec.imm = XLEN'(imm32);
    end

    // The skid entry is only ever occupied while the output register is, so in_ready
    // is simply "skid empty" and never looks at out_ready.
    assign accept  = imm_if.in_valid && !skid_valid_q;
    assign deliver = out_valid_q && imm_if.out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (deliver) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_valid_q) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end else begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign imm_if.in_ready    = !skid_valid_q;
    assign imm_if.out_valid   = out_valid_q;
    assign imm_if.out_imm     = out_q.imm;
    assign imm_if.out_type    = out_q.typ;
    assign imm_if.out_illegal = out_q.ill;
endmodule

// File: tb/tb_pipelined_imm_gen.sv
// Bench for pipelined_imm_gen: XLEN=32 and XLEN=64 instances driven in lockstep and
// compared against a field-arithmetic reference model through an expected-result queue.
module tb_pipelined_imm_gen;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    pipelined_imm_gen_if #(.XLEN(32)) bus32 ();
    pipelined_imm_gen_if #(.XLEN(64)) bus64 ();

    pipelined_imm_gen #(.XLEN(32)) dut32 (.clk(clk), .reset_n(reset_n), .imm_if(bus32.slave));
    pipelined_imm_gen #(.XLEN(64)) dut64 (.clk(clk), .reset_n(reset_n), .imm_if(bus64.slave));

    // Expected queue entry: {imm as 64-bit two's complement, type[2:0], illegal}
    logic [67:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reassemble each immediate from its fields as an integer, then sign-fold.
    function automatic logic [67:0] model(input logic [31:0] inst);
        int unsigned op;
        longint      val;
        int          width;
        logic [2:0]  t;
        logic        ill;
        op    = inst & 32'h7F;
        val   = 0;
        width = 0;
        t     = 3'd0;
        ill   = 1'b0;
        case (op)
            32'h13, 32'h03, 32'h67: begin t = 3'd1; width = 12; val = inst >> 20; end
            32'h23: begin
                t = 3'd2; width = 12;
                val = ((inst >> 25) & 127) * 32 + ((inst >> 7) & 31);
            end
            32'h63: begin
                t = 3'd3; width = 13;
                val = ((inst >> 31) & 1) * 4096 + ((inst >> 7) & 1) * 2048
                    + ((inst >> 25) & 63) * 32 + ((inst >> 8) & 15) * 2;
            end
            32'h6F: begin
                t = 3'd5; width = 21;
                val = ((inst >> 31) & 1) * 1048576 + ((inst >> 12) & 255) * 4096
                    + ((inst >> 20) & 1) * 2048 + ((inst >> 21) & 1023) * 2;
            end
            32'h33, 32'h73: t = 3'd0;
`ifdef IMMGEN_UTYPE_EN
            32'h37, 32'h17: begin t = 3'd4; width = 32; val = (inst >> 12) * 4096; end
`endif
            default: ill = 1'b1;
        endcase
        if (width > 0 && val >= (longint'(1) << (width - 1)))
            val = val - (longint'(1) << width);
        return {64'(val), t, ill};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic ordy);
        bus32.in_valid  = v;
        bus32.in_inst   = inst;
        bus32.out_ready = ordy;
        bus64.in_valid  = v;
        bus64.in_inst   = inst;
        bus64.out_ready = ordy;
    endtask

    task automatic check_outputs(input logic [67:0] head);
        chk("imm32",  64'(bus32.out_imm), {32'd0, head[35:4]});
        chk("imm64",  bus64.out_imm, head[67:4]);
        chk("type32", 64'(bus32.out_type), 64'(head[3:1]));
        chk("type64", 64'(bus64.out_type), 64'(head[3:1]));
        chk("ill32",  64'(bus32.out_illegal), 64'(head[0]));
        chk("ill64",  64'(bus64.out_illegal), 64'(head[0]));
    endtask

    // One clock: drive at negedge, check visible state, then advance the model to the next edge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic ordy);
        int cnt;
        @(negedge clk);
        drive(v, inst, ordy);
        #1;
        cnt = exp_q.size();
        chk("out_valid32", 64'(bus32.out_valid), 64'(cnt > 0));
        chk("out_valid64", 64'(bus64.out_valid), 64'(cnt > 0));
        chk("in_ready32",  64'(bus32.in_ready),  64'(cnt < 2));
        chk("in_ready64",  64'(bus64.in_ready),  64'(cnt < 2));
        if (cnt > 0) check_outputs(exp_q[0]);
        if (cnt > 0 && ordy) void'(exp_q.pop_front());
        if (v && cnt < 2) exp_q.push_back(model(inst));
    endtask

    // Literal known-answer check of what is presented right now.
    task automatic known(input string tag, input logic [63:0] imm, input logic [2:0] t, input logic ill);
        chk({tag, "_valid"}, 64'(bus32.out_valid), 64'd1);
        chk({tag, "_imm32"}, 64'(bus32.out_imm), {32'd0, imm[31:0]});
        chk({tag, "_imm64"}, bus64.out_imm, imm);
        chk({tag, "_type"},  64'(bus64.out_type), 64'(t));
        chk({tag, "_ill"},   64'(bus64.out_illegal), 64'(ill));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid32"}, 64'(bus32.out_valid), 64'd0);
        chk({tag, "_valid64"}, 64'(bus64.out_valid), 64'd0);
        chk({tag, "_ready32"}, 64'(bus32.in_ready), 64'd1);
        chk({tag, "_ready64"}, 64'(bus64.in_ready), 64'd1);
        chk({tag, "_imm64"},   bus64.out_imm, 64'd0);
        chk({tag, "_imm32"},   64'(bus32.out_imm), 64'd0);
        chk({tag, "_type"},    64'(bus64.out_type), 64'd0);
        chk({tag, "_ill"},     64'(bus64.out_illegal), 64'd0);
    endtask

    logic [6:0] ops [12];

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        checks  = 0;
        errors  = 0;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h73, 7'h37, 7'h17, 7'h7F, 7'h00};
        reset_n = 1'b0;
        drive(1'b0, 32'd0, 1'b1);
        #3;
        check_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // addi x1, x0, -1
        cycle(1'b1, 32'hFFF00093, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        known("addi", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);

        // sw then jal back-to-back
        cycle(1'b1, 32'hFE112E23, 1'b1);
        cycle(1'b1, 32'h008000EF, 1'b1);
        known("sw", 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
        cycle(1'b0, 32'd0, 1'b1);
        known("jal", 64'd8, 3'd5, 1'b0);

        cycle(1'b1, 32'h12345037, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
`ifdef IMMGEN_UTYPE_EN
        known("lui", 64'h0000_0000_1234_5000, 3'd4, 1'b0);
`else
        known("lui", 64'd0, 3'd0, 1'b1);
`endif

        cycle(1'b1, 32'h0000007F, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        known("op7f", 64'd0, 3'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);

        // Stall with three offered: two taken, third held until space returns.
        cycle(1'b1, 32'h00500113, 1'b0);
        cycle(1'b1, 32'h80000063, 1'b0);
        cycle(1'b1, 32'hFFDFF06F, 1'b0);
        cycle(1'b1, 32'hFFDFF06F, 1'b0);
        cycle(1'b1, 32'hFFDFF06F, 1'b1);
        cycle(1'b1, 32'hFFDFF06F, 1'b1);
        repeat (3) cycle(1'b0, 32'd0, 1'b1);

        // Reset mid-operation with both slots full.
        cycle(1'b1, 32'h00A00513, 1'b0);
        cycle(1'b1, 32'h00B00593, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        drive(1'b0, 32'd0, 1'b1);
        #1;
        check_reset_state("midreset");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 32'h7FF00093, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        known("post_reset", 64'd2047, 3'd1, 1'b0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            r  = $urandom();
            op = ops[$urandom_range(0, 11)];
            if (op == 7'h00) op = r[6:0];
            cycle($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom_range(0, 3) != 0);
        end
        repeat (4) cycle(1'b0, 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_imm_gen.md
PIPELINED_IMM_GEN -- requirements
Module: pipelined_imm_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-006 SHALL have port in_inst  input  32  raw RV instruction word.
REQ-007 SHALL have port out_valid  output  1  decoded result valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts result.
REQ-009 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-010 SHALL have port out_type  output  3  format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-011 SHALL have port out_illegal  output  1  opcode not recognised.

Function
REQ-012 SHALL transfer input on in_valid&&in_ready and output on out_valid&&out_ready.
REQ-013 SHALL contain an output register plus one skid entry; capacity exactly 2 instructions.
REQ-014 SHALL give latency 1: an instruction accepted in cycle N is presented at out_* in cycle N+1 when the output register is empty or draining.
REQ-015 SHALL drive in_ready from a register: high iff skid entry empty; never combinationally from out_ready.
REQ-016 SHALL sustain one transfer per cycle when out_ready held high.
REQ-017 SHALL, when out stalled and output full, place the new accept into skid; next out handshake moves skid to output same edge.
REQ-018 SHALL preserve strict in-order delivery; no drop, no duplicate.
REQ-019 SHALL hold out_imm/out_type/out_illegal stable while out_valid && !out_ready.
REQ-020 SHALL decode opcode in_inst[6:0]: 0010011, 0000011, 1100111 -> I {inst[31:20]}.
REQ-021 SHALL decode 0100011 -> S {inst[31:25],inst[11:7]}.
REQ-022 SHALL decode 1100011 -> B {inst[31],inst[7],inst[30:25],inst[11:8],0}.
REQ-023 SHALL decode 1101111 -> J {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-024 SHALL decode 0110011 and 1110011 -> type 0, imm 0, illegal 0.
REQ-025 SHALL give any other opcode type 0, imm 0, illegal 1; the instruction still flows through.
REQ-026 SHALL sign-extend every immediate from inst[31] to full XLEN.
REQ-027 SHALL handle simultaneous accept and deliver with both slots busy: in_ready low, so accept impossible; with output only busy: deliver and refill in same cycle.

Reset
REQ-028 SHALL asynchronously clear both valid bits, so out_valid=0, and set in_ready=1, out_imm=0, out_type=0, out_illegal=0.
REQ-029 SHALL discard any in-flight instructions on reset mid-operation; first post-reset accept is on the first edge with reset_n high.

Configuration
REQ-030 SHALL support macro IMMGEN_UTYPE_EN; when defined, 0110111 and 0010111 decode as U: {inst[31:12],12'b0} sign-extended, type 4, illegal 0.
REQ-031 SHALL, without IMMGEN_UTYPE_EN, treat 0110111 and 0010111 per REQ-025: imm 0, type 0, illegal 1.

Verification
REQ-032 SHALL check addi 0xFFF00093, XLEN=32, out_ready=1 -> next cycle out_imm 0xFFFFFFFF, type 1, illegal 0.
REQ-033 SHALL check sw 0xFE112E23 then jal 0x008000EF back-to-back, XLEN=64 -> imm 0xFFFF_FFFF_FFFF_FFFC type 2, then imm 8 type 5, consecutive cycles.
REQ-034 SHALL check lui 0x12345037 -> with IMMGEN_UTYPE_EN imm 0x12345000 type 4; without it imm 0 type 0 illegal 1.
REQ-035 SHALL check out_ready=0, in_valid=1 for 3 cycles -> 2 accepted, in_ready low after second, outputs held; release -> results in order, no loss.
REQ-036 SHALL check reset_n pulsed low with both slots full -> out_valid 0 and in_ready 1 immediately; no stale output after release.
REQ-037 SHALL check opcode 0x7F -> imm 0, type 0, illegal 1, delivered with normal handshake.
